// File: rtl/branch_update_ctrl_pkg.sv
// Shared types and helpers for the branch predictor update controller:
// FSM state encoding, 2-bit counter constants and the saturating update rule.
package branch_update_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } upd_state_e;

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  // Saturating 2-bit counter step; the end checks make wrap impossible.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] result;
    if (taken) begin
      result = (cnt == STRONG_T) ? STRONG_T : cnt + 2'd1;
    end else begin
      result = (cnt == STRONG_NT) ? STRONG_NT : cnt - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_update_ctrl_if.sv
// Commit handshake from the ROB plus the predictor read/write ports.
// master = the update controller, slave = ROB/predictor side.
interface branch_update_ctrl_if;

  logic        commitValid;
  logic        commitReady;
  logic [31:0] commitAddr;
  logic        commitTaken;
  logic        commitPredTaken;
  logic [31:0] predRdAddr;
  logic [1:0]  predRdData;
  logic        predWrEn;
  logic [31:0] predWrAddr;
  logic [1:0]  predWrData;

  modport master (
    input  commitValid, commitAddr, commitTaken, commitPredTaken, predRdData,
    output commitReady, predRdAddr, predWrEn, predWrAddr, predWrData
  );

  modport slave (
    output commitValid, commitAddr, commitTaken, commitPredTaken, predRdData,
    input  commitReady, predRdAddr, predWrEn, predWrAddr, predWrData
  );

endinterface

// File: rtl/branch_update_fifo.sv
// Parameterised synchronous FIFO (power-of-two depth) with async active-low
// reset, full/empty flags and a combinational head output.
module branch_update_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_update_ctrl.sv
// Buffers resolved-branch commits and sequences read/modify/write updates of
// the 2-bit predictor table. Optional counters: `define BRANCH_STATS_EN.
module branch_update_ctrl
  import branch_update_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int IDX_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_update_ctrl_if.master bus,
`ifdef BRANCH_STATS_EN
  output logic [31:0]          statCommits,
  output logic [31:0]          statMispredicts,
`endif
  output logic                 busy
);

  localparam int ENTRY_W = IDX_W + 2;

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               pop;

  upd_state_e         state_q;
  upd_state_e         state_d;
  logic [IDX_W-1:0]   work_idx;
  logic               work_taken;
  logic [31:0]        rd_addr_q;
  logic               wr_en_q;
  logic [31:0]        wr_addr_q;
  logic [1:0]         wr_data_q;

  // Entry layout: {index, taken, predTaken}.
  assign push_entry      = {bus.commitAddr[IDX_W+1:2], bus.commitTaken, bus.commitPredTaken};
  assign accept          = bus.commitValid && !fifo_full;
  assign bus.commitReady = !fifo_full;

  branch_update_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = READ;
        end
      end
      READ:    state_d = WRITE;
      WRITE:   state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The write strobe is registered so the edge-triggered table sees one clean pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_idx   <= '0;
      work_taken <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= (state_q == READ);
      if (pop) begin
        work_idx   <= head[ENTRY_W-1:2];
        work_taken <= head[1];
        rd_addr_q  <= {{(32-IDX_W){1'b0}}, head[ENTRY_W-1:2]};
      end
      if (state_q == READ) begin
        wr_addr_q <= {{(32-IDX_W){1'b0}}, work_idx};
        wr_data_q <= sat_update(bus.predRdData, work_taken);
      end
    end
  end

  assign bus.predRdAddr = rd_addr_q;
  assign bus.predWrEn   = wr_en_q;
  assign bus.predWrAddr = wr_addr_q;
  assign bus.predWrData = wr_data_q;
  assign busy           = !fifo_empty || (state_q != IDLE);

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statCommits     <= '0;
      statMispredicts <= '0;
    end else if (accept) begin
      statCommits <= statCommits + 32'd1;
      if (bus.commitTaken != bus.commitPredTaken) statMispredicts <= statMispredicts + 32'd1;
    end
  end
`endif

  // Byte-offset/upper PC bits and the stored prediction bit do not affect the update.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.commitAddr[31:IDX_W+2], bus.commitAddr[1:0], head[0]};

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Randomised self-checking bench for branch_update_ctrl with a behavioural
// predictor table and a queue-based reference of expected counter updates.
module tb_branch_update_ctrl;

  localparam int IDX_W  = 10;
  localparam int QDEPTH = 4;
  localparam int TBL_N  = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_commits;
  logic [31:0] stat_mispredicts;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] pred_tbl [TBL_N];
  int         ref_tbl  [TBL_N];
  int         wr_addr_q [$];
  int         wr_data_q [$];
  int         exp_idx_q [$];
  bit         exp_taken_q [$];

  branch_update_ctrl_if bus ();

  branch_update_ctrl #(
    .QDEPTH (QDEPTH),
    .IDX_W  (IDX_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
`ifdef BRANCH_STATS_EN
    .statCommits     (stat_commits),
    .statMispredicts (stat_mispredicts),
`endif
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Predictor model: combinational read port, table updated on the write-enable edge.
  assign bus.predRdData = pred_tbl[bus.predRdAddr[IDX_W-1:0]];

  always @(posedge bus.predWrEn) begin
    #1;
    pred_tbl[bus.predWrAddr[IDX_W-1:0]] = bus.predWrData;
    wr_addr_q.push_back(int'(bus.predWrAddr));
    wr_data_q.push_back(int'(bus.predWrData));
  end

  function automatic int ref_next(input int cnt, input bit taken);
    if (taken) return (cnt >= 3) ? 3 : cnt + 1;
    return (cnt <= 0) ? 0 : cnt - 1;
  endfunction

  task automatic set_entry(input int idx, input int val);
    logic [1:0] v2;
    v2 = val[1:0];
    pred_tbl[idx] = v2;
    ref_tbl[idx]  = val;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_idx_q.delete();
    exp_taken_q.delete();
  endtask

  task automatic apply_reset();
    bus.commitValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  // Offer one commit starting at a negedge; leaves commitValid high on return.
  task automatic offer(input logic [31:0] addr, input bit taken, input bit pred, output bit waited);
    int guard;
    bus.commitValid     = 1'b1;
    bus.commitAddr      = addr;
    bus.commitTaken     = taken;
    bus.commitPredTaken = pred;
    waited = 1'b0;
    guard  = 0;
    while (!bus.commitReady && guard < 200) begin
      waited = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL offer_timeout: commitReady=%0b required=1", bus.commitReady);
    end else begin
      @(posedge clk);
      @(negedge clk);
      exp_idx_q.push_back(int'(addr[IDX_W+1:2]));
      exp_taken_q.push_back(taken);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    if (guard >= 500) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: busy=%0b required=0", busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors += 6;
    if (bus.commitReady !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %0b want 1", bus.commitReady); end
    if (bus.predWrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wren: got %0b want 0", bus.predWrEn); end
    if (bus.predWrAddr !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_wraddr: got %0h want 0", bus.predWrAddr); end
    if (bus.predWrData !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_wrdata: got %0d want 0", bus.predWrData); end
    if (bus.predRdAddr !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdaddr: got %0h want 0", bus.predRdAddr); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
`ifdef BRANCH_STATS_EN
    vectors++;
    if (stat_commits !== 32'd0 || stat_mispredicts !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_stats: got %0d/%0d want 0/0", stat_commits, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_single();
    set_entry(16, 1);
    bus.commitValid = 1'b1;
    bus.commitAddr = 32'h40;
    bus.commitTaken = 1'b1;
    bus.commitPredTaken = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.commitValid = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (bus.predRdAddr !== 32'h10) begin miscompares++; $display("[TB] FAIL single_rdaddr: got %0h want 10", bus.predRdAddr); end
    if (bus.predWrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL single_wren_read: got %0b want 0", bus.predWrEn); end
    @(negedge clk);
    vectors += 3;
    if (bus.predWrEn !== 1'b1) begin miscompares++; $display("[TB] FAIL single_wren: got %0b want 1", bus.predWrEn); end
    if (bus.predWrAddr !== 32'h10) begin miscompares++; $display("[TB] FAIL single_wraddr: got %0h want 10", bus.predWrAddr); end
    if (bus.predWrData !== 2'd2) begin miscompares++; $display("[TB] FAIL single_wrdata: got %0d want 2", bus.predWrData); end
    @(negedge clk);
    vectors += 3;
    if (bus.predWrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL single_release_wren: got %0b want 0", bus.predWrEn); end
    if (bus.predWrData !== 2'd2) begin miscompares++; $display("[TB] FAIL single_release_hold: got %0d want 2", bus.predWrData); end
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_release: got %0b want 1", busy); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_done: got %0b want 0", busy); end
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_addr_q.size() !== 1) begin miscompares++; $display("[TB] FAIL single_pulse_count: got %0d want 1", wr_addr_q.size()); end
    ref_tbl[16] = 2;
    clear_logs();
  endtask

  task automatic test_saturation();
    bit w;
    set_entry(33, 3);
    set_entry(34, 0);
    offer(32'h84, 1'b1, 1'b1, w);
    offer(32'h88, 1'b0, 1'b0, w);
    bus.commitValid = 1'b0;
    drain();
    vectors++;
    if (wr_data_q.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL sat_count: got %0d want 2", wr_data_q.size());
    end else begin
      vectors += 2;
      if (wr_addr_q[0] !== 33 || wr_data_q[0] !== 3) begin miscompares++; $display("[TB] FAIL sat_high: got %0h/%0d want 21/3", wr_addr_q[0], wr_data_q[0]); end
      if (wr_addr_q[1] !== 34 || wr_data_q[1] !== 0) begin miscompares++; $display("[TB] FAIL sat_low: got %0h/%0d want 22/0", wr_addr_q[1], wr_data_q[1]); end
    end
    clear_logs();
  endtask

  task automatic test_stream();
    bit w;
    bit saw_full;
    int idx, e, a, d;
    bit tk;
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_entry(100 + i, int'($urandom_range(0, 3)));
      offer(32'((100 + i) << 2), 1'($urandom_range(0, 1)), 1'b0, w);
      saw_full |= w;
    end
    bus.commitValid = 1'b0;
    vectors++;
    if (saw_full !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_backpressure: got %0b want 1", saw_full); end
    drain();
    vectors++;
    if (wr_addr_q.size() !== exp_idx_q.size()) begin
      miscompares++;
      $display("[TB] FAIL stream_count: got %0d want %0d", wr_addr_q.size(), exp_idx_q.size());
    end
    while (exp_idx_q.size() > 0 && wr_addr_q.size() > 0) begin
      idx = exp_idx_q.pop_front();
      tk  = exp_taken_q.pop_front();
      e   = ref_next(ref_tbl[idx], tk);
      ref_tbl[idx] = e;
      a = wr_addr_q.pop_front();
      d = wr_data_q.pop_front();
      vectors++;
      if (a !== idx || d !== e) begin miscompares++; $display("[TB] FAIL stream_write: got %0h/%0d want %0h/%0d", a, d, idx, e); end
    end
    clear_logs();
  endtask

  task automatic test_same_index();
    bit w;
    set_entry(32, 0);
    offer(32'h80, 1'b1, 1'b0, w);
    offer(32'h80, 1'b1, 1'b0, w);
    bus.commitValid = 1'b0;
    drain();
    vectors += 2;
    if (wr_data_q.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL same_count: got %0d want 2", wr_data_q.size());
    end else if (wr_data_q[0] !== 1 || wr_data_q[1] !== 2) begin
      miscompares++;
      $display("[TB] FAIL same_values: got %0d,%0d want 1,2", wr_data_q[0], wr_data_q[1]);
    end
    if (pred_tbl[32] !== 2'd2) begin miscompares++; $display("[TB] FAIL same_final: got %0d want 2", pred_tbl[32]); end
    ref_tbl[32] = 2;
    clear_logs();
  endtask

  task automatic test_random();
    bit w;
    int idx, e, a, d;
    bit tk;
    logic [31:0] addr;
    for (int i = 0; i < 8; i++) set_entry(200 + i, int'($urandom_range(0, 3)));
    for (int i = 0; i < 24; i++) begin
      addr = $urandom;
      addr[IDX_W+1:2] = IDX_W'(200 + $urandom_range(0, 7));
      offer(addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      bus.commitValid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    vectors++;
    if (wr_addr_q.size() !== exp_idx_q.size()) begin
      miscompares++;
      $display("[TB] FAIL random_count: got %0d want %0d", wr_addr_q.size(), exp_idx_q.size());
    end
    while (exp_idx_q.size() > 0 && wr_addr_q.size() > 0) begin
      idx = exp_idx_q.pop_front();
      tk  = exp_taken_q.pop_front();
      e   = ref_next(ref_tbl[idx], tk);
      ref_tbl[idx] = e;
      a = wr_addr_q.pop_front();
      d = wr_data_q.pop_front();
      vectors++;
      if (a !== idx || d !== e) begin miscompares++; $display("[TB] FAIL random_write: got %0h/%0d want %0h/%0d", a, d, idx, e); end
    end
    clear_logs();
  endtask

  task automatic test_reset_mid();
    bit w;
    int guard, nw;
    for (int i = 0; i < 5; i++) offer(32'((300 + i) << 2), 1'b1, 1'b0, w);
    bus.commitValid = 1'b0;
    guard = 0;
    while (bus.predWrEn !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 50) begin miscompares++; $display("[TB] FAIL midreset_no_write: predWrEn=%0b want 1", bus.predWrEn); end
    #1;
    rst_n = 1'b0;
    #1;
    nw = wr_addr_q.size();
    vectors += 3;
    if (bus.predWrEn !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_wren_async: got %0b want 0", bus.predWrEn); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy_async: got %0b want 0", busy); end
    if (bus.commitReady !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_ready: got %0b want 1", bus.commitReady); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors += 2;
    if (wr_addr_q.size() !== nw) begin miscompares++; $display("[TB] FAIL midreset_extra_writes: got %0d want %0d", wr_addr_q.size(), nw); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy: got %0b want 0", busy); end
    clear_logs();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    bit w;
    bit tk [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit pr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 5; i++) offer(32'((400 + i) << 2), tk[i], pr[i], w);
    bus.commitValid = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (stat_commits !== 32'd5) begin miscompares++; $display("[TB] FAIL stats_commits: got %0d want 5", stat_commits); end
    if (stat_mispredicts !== 32'd2) begin miscompares++; $display("[TB] FAIL stats_mispredicts: got %0d want 2", stat_mispredicts); end
    drain();
    clear_logs();
  endtask
`endif

  initial begin
    bus.commitValid = 1'b0;
    bus.commitAddr = '0;
    bus.commitTaken = 1'b0;
    bus.commitPredTaken = 1'b0;
    for (int i = 0; i < TBL_N; i++) begin
      pred_tbl[i] = 2'd0;
      ref_tbl[i] = 0;
    end
    test_reset();
    test_single();
    test_saturation();
    test_stream();
    test_same_index();
    test_random();
    test_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_update_ctrl.md
Name: branch_update_ctrl

Overview:
Sequences training updates into the 2-bit branch predictor table, which has a single write port and an edge-triggered write enable.
- Accepts resolved-branch commits from the ROB through a ready/valid interface and buffers them in a small FIFO.
- For each commit: reads the current counter through the predictor's ROB read port, computes the saturated next value, then issues one clean write-enable pulse.
- Sits between ROB commit logic and the predictor; it is the only driver of the predictor write port.

Parameters:
QDEPTH, 4, update FIFO entries (power of two, >=2)
IDX_W, 10, predictor table index width (table size 1<<IDX_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
commitValid  in  1  resolved branch offered
commitReady  out  1  FIFO can accept (= !full)
commitAddr  in  32  byte PC of resolved branch
commitTaken  in  1  actual outcome
commitPredTaken  in  1  prediction used at fetch (statistics only)
predRdAddr  out  32  to predictor ROB read address
predRdData  in  2  predictor ROB read counter
predWrEn  out  1  predictor write enable (edge-triggered consumer)
predWrAddr  out  32  predictor write address
predWrData  out  2  new counter value
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Commit handshake and FIFO
  - A commit is accepted on a rising clk when commitValid && commitReady.
  - FIFO stores {index, taken, predTaken}.
  - index = commitAddr[IDX_W+1:2], zero-extended to 32 bits on predRdAddr/predWrAddr.
  - Full: commitReady=0; input is ignored and no overwrite occurs.
  - Push and pop in the same cycle are allowed when not full. The occupancy count is unchanged and the pointers wrap modulo QDEPTH.
- FSM states: IDLE, READ, WRITE, RELEASE.
  - IDLE: if FIFO non-empty, pop the head into working registers -> READ.
  - READ: predRdAddr = working index. At the end of the cycle, capture predRdData into cnt -> WRITE.
  - WRITE: predWrEn=1, predWrAddr=index, predWrData=next(cnt) -> RELEASE.
  - RELEASE: predWrEn=0, address and data held -> IDLE.
- Timing and hazards
  - Latency is 4 cycles per update; the head entry is popped in IDLE.
  - Back-to-back updates to the same index are correct because every read follows the previous write's release.
- Saturating counter update
  - Taken: 3 -> 3, else cnt+1.
  - Not taken: 0 -> 0, else cnt-1.
  - All arithmetic is 2-bit; wrap is impossible by construction.
- Output values
  - predWrEn, predWrAddr and predWrData are registered, so there are no glitches on predWrEn.
  - predRdAddr holds its last value outside READ.
- Reset values
  - commitReady=1, predWrEn=0, predWrAddr=0, predWrData=0, predRdAddr=0, busy=0.
  - FIFO is emptied; FSM -> IDLE.
  - Reset asserted mid-update drops predWrEn immediately (async) and discards the in-flight entry and all queued entries.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - Ports statCommits[31:0] and statMispredicts[31:0] (out) are added.
  - statCommits increments on each accepted commit.
  - statMispredicts increments when an accepted commit has commitTaken != commitPredTaken.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters are absent, and commitPredTaken is unused.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, READ=1, WRITE=2, RELEASE=3).
  - Counter constants (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3).
  - The saturating-update function.
- One sub-module: branch_update_fifo, a parameterised synchronous FIFO with async reset and full/empty flags.

Test Plan:
- Reset, then one commit (addr 0x40, taken) with predRdData=1.
  - READ drives predRdAddr=0x10.
  - Exactly one predWrEn pulse follows, with predWrAddr=0x10 and predWrData=2.
  - busy returns to 0 four cycles after the pop.
- Saturation:
  - predRdData=3 with taken -> predWrData=3.
  - predRdData=0 with not-taken -> predWrData=0.
- Stream: hold commitValid for 10 commits at QDEPTH=4.
  - commitReady drops once the FIFO is full.
  - All 10 updates are written in order, with no loss and no duplication.
- Same-index pair: taken then taken to addr 0x80, with a bench-modelled table starting at 0.
  - Second read returns 1.
  - Final table entry is 2.
- Assert rst_n low during WRITE with 3 entries queued.
  - predWrEn goes to 0 asynchronously.
  - After release, no writes occur and busy=0.
- With BRANCH_STATS_EN: 5 commits, 2 of them with taken != predTaken -> statCommits=5, statMispredicts=2.
